// File: rtl/demod_pkg.sv
// Shared types and default widths for the demodulation mixer scheduler.
package demod_pkg;

    localparam int unsigned NumChDef  = 4;
    localparam int unsigned ChWDef    = 2;
    localparam int unsigned AddrWDef  = 10;
    localparam int unsigned InWDef    = 16;
    localparam int unsigned OutWDef   = 16;
    localparam int unsigned AccWDef   = 32;
    localparam int unsigned WinWDef   = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDump
    } state_e;

endpackage

// File: rtl/nco_bank.sv
// Per-channel NCO state: programmed fcw/phase, working shadows and phase advance.
module nco_bank
    import demod_pkg::*;
#(
    parameter int unsigned NUM_CH = NumChDef,
    parameter int unsigned CH_W   = ChWDef,
    parameter int unsigned ADDR_W = AddrWDef
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [ADDR_W-1:0] cfg_fcw_i,
    input  logic [ADDR_W-1:0] cfg_phase_i,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic [CH_W-1:0]   adv_ch_i,
    output logic [ADDR_W-1:0] phase_o
);

    logic [ADDR_W-1:0] fcw_cfg_q [NUM_CH];
    logic [ADDR_W-1:0] fcw_cfg_d [NUM_CH];
    logic [ADDR_W-1:0] ph_cfg_q  [NUM_CH];
    logic [ADDR_W-1:0] ph_cfg_d  [NUM_CH];
    logic [ADDR_W-1:0] fcw_sh_q  [NUM_CH];
    logic [ADDR_W-1:0] fcw_sh_d  [NUM_CH];
    logic [ADDR_W-1:0] ph_sh_q   [NUM_CH];
    logic [ADDR_W-1:0] ph_sh_d   [NUM_CH];

    // Config writes, shadow load on window start, phase step after each issue slot.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            fcw_cfg_d[c] = fcw_cfg_q[c];
            ph_cfg_d[c]  = ph_cfg_q[c];
            fcw_sh_d[c]  = fcw_sh_q[c];
            ph_sh_d[c]   = ph_sh_q[c];
            if (cfg_we_i && cfg_ch_i == CH_W'(c)) begin
                fcw_cfg_d[c] = cfg_fcw_i;
                ph_cfg_d[c]  = cfg_phase_i;
            end
            if (load_i) begin
                fcw_sh_d[c] = fcw_cfg_q[c];
                ph_sh_d[c]  = ph_cfg_q[c];
            end else if (adv_i && adv_ch_i == CH_W'(c)) begin
                ph_sh_d[c] = ph_sh_q[c] + fcw_sh_q[c];
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                fcw_cfg_q[c] <= '0;
                ph_cfg_q[c]  <= '0;
                fcw_sh_q[c]  <= '0;
                ph_sh_q[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                fcw_cfg_q[c] <= fcw_cfg_d[c];
                ph_cfg_q[c]  <= ph_cfg_d[c];
                fcw_sh_q[c]  <= fcw_sh_d[c];
                ph_sh_q[c]   <= ph_sh_d[c];
            end
        end
    end

    assign phase_o = ph_sh_q[adv_ch_i];

endmodule

// File: rtl/demod_mixer_scheduler.sv
// Time-multiplexes one shared mixer over NUM_CH channels and integrates I/Q per window.
module demod_mixer_scheduler
    import demod_pkg::*;
#(
    parameter int unsigned NUM_CH       = NumChDef,
    parameter int unsigned CH_W         = ChWDef,
    parameter int unsigned ADDR_W       = AddrWDef,
    parameter int unsigned INPUT_WIDTH  = InWDef,
    parameter int unsigned OUTPUT_WIDTH = OutWDef,
    parameter int unsigned ACC_WIDTH    = AccWDef,
    parameter int unsigned WIN_W        = WinWDef
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [ADDR_W-1:0]       cfg_fcw,
    input  logic [ADDR_W-1:0]       cfg_phase,
    input  logic                    start,
    input  logic [WIN_W-1:0]        win_len,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [INPUT_WIDTH-1:0]  s_i,
    input  logic [INPUT_WIDTH-1:0]  s_q,
    output logic [ADDR_W-1:0]       lut_addr,
    input  logic [INPUT_WIDTH-1:0]  lut_cos,
    input  logic [INPUT_WIDTH-1:0]  lut_sin,
    output logic [INPUT_WIDTH-1:0]  mix_i_in_1,
    output logic [INPUT_WIDTH-1:0]  mix_q_in_1,
    output logic [INPUT_WIDTH-1:0]  mix_i_in_2,
    output logic [INPUT_WIDTH-1:0]  mix_q_in_2,
    input  logic [OUTPUT_WIDTH-1:0] mix_i_out,
    input  logic [OUTPUT_WIDTH-1:0] mix_q_out,
    output logic                    acc_valid,
    output logic [CH_W-1:0]         acc_ch,
    output logic [ACC_WIDTH-1:0]    acc_i,
    output logic [ACC_WIDTH-1:0]    acc_q,
    output logic                    busy,
    output logic                    done
);

    localparam logic [CH_W-1:0] LastCh = CH_W'(NUM_CH - 1);

    state_e                 state_q, state_d;
    logic [WIN_W-1:0]       cnt_q, cnt_d, win_q, win_d;
    logic [CH_W-1:0]        dump_ch_q, dump_ch_d;
    logic                   done_q, done_d;
    logic                   load, s_acc;

    logic                   iss_valid_q, iss_valid_d, mix_valid_q;
    logic [CH_W-1:0]        iss_ch_q, iss_ch_d, mix_ch_q;
    logic [INPUT_WIDTH-1:0] iss_i_q, iss_i_d, iss_q_q, iss_q_d, mix_i_q, mix_q_q;
    logic [ADDR_W-1:0]      phase;

    logic [ACC_WIDTH-1:0]   acc_i_q [NUM_CH];
    logic [ACC_WIDTH-1:0]   acc_i_d [NUM_CH];
    logic [ACC_WIDTH-1:0]   acc_q_q [NUM_CH];
    logic [ACC_WIDTH-1:0]   acc_q_d [NUM_CH];
    logic [ACC_WIDTH-1:0]   mix_i_ext, mix_q_ext;

    // A new sample may enter as the issue stage finishes its last channel slot.
    assign s_ready = (state_q == StRun) && (!iss_valid_q || iss_ch_q == LastCh) &&
                     (cnt_q != win_q);
    assign s_acc   = s_valid && s_ready;

    // Window control FSM: next state, sample count and dump sequencing.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        dump_ch_d = dump_ch_q;
        done_d    = 1'b0;
        load      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    load      = 1'b1;
                    cnt_d     = '0;
                    win_d     = win_len;
                    dump_ch_d = '0;
                    state_d   = (win_len == '0) ? StDump : StRun;
                end
            end
            StRun: begin
                if (s_acc) begin
                    cnt_d = cnt_q + WIN_W'(1);
                    if (cnt_d == win_q) state_d = StDrain;
                end
            end
            StDrain: begin
                if (!iss_valid_q && !mix_valid_q) state_d = StDump;
            end
            StDump: begin
                dump_ch_d = dump_ch_q + CH_W'(1);
                if (dump_ch_q == LastCh) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Issue stage walks channels 0..NUM_CH-1 for the held sample.
    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_ch_d    = iss_ch_q;
        iss_i_d     = iss_i_q;
        iss_q_d     = iss_q_q;
        if (iss_valid_q) begin
            iss_ch_d = iss_ch_q + CH_W'(1);
            if (iss_ch_q == LastCh) iss_valid_d = 1'b0;
        end
        if (s_acc) begin
            iss_valid_d = 1'b1;
            iss_ch_d    = '0;
            iss_i_d     = s_i;
            iss_q_d     = s_q;
        end
    end

    assign mix_i_ext = {{(ACC_WIDTH-OUTPUT_WIDTH){mix_i_out[OUTPUT_WIDTH-1]}}, mix_i_out};
    assign mix_q_ext = {{(ACC_WIDTH-OUTPUT_WIDTH){mix_q_out[OUTPUT_WIDTH-1]}}, mix_q_out};

    // Integrators: cleared on window start, accumulate the mix-stage channel.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            acc_i_d[c] = load ? '0 : acc_i_q[c];
            acc_q_d[c] = load ? '0 : acc_q_q[c];
        end
        if (!load && mix_valid_q) begin
            acc_i_d[mix_ch_q] = acc_i_q[mix_ch_q] + mix_i_ext;
            acc_q_d[mix_ch_q] = acc_q_q[mix_ch_q] + mix_q_ext;
        end
    end

    // State, pipeline and integrator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            win_q       <= '0;
            dump_ch_q   <= '0;
            done_q      <= 1'b0;
            iss_valid_q <= 1'b0;
            iss_ch_q    <= '0;
            iss_i_q     <= '0;
            iss_q_q     <= '0;
            mix_valid_q <= 1'b0;
            mix_ch_q    <= '0;
            mix_i_q     <= '0;
            mix_q_q     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_i_q[c] <= '0;
                acc_q_q[c] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            dump_ch_q   <= dump_ch_d;
            done_q      <= done_d;
            iss_valid_q <= iss_valid_d;
            iss_ch_q    <= iss_ch_d;
            iss_i_q     <= iss_i_d;
            iss_q_q     <= iss_q_d;
            mix_valid_q <= iss_valid_q;
            mix_ch_q    <= iss_ch_q;
            mix_i_q     <= iss_i_q;
            mix_q_q     <= iss_q_q;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_i_q[c] <= acc_i_d[c];
                acc_q_q[c] <= acc_q_d[c];
            end
        end
    end

    nco_bank #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .ADDR_W (ADDR_W)
    ) u_nco_bank (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_we_i    (cfg_we),
        .cfg_ch_i    (cfg_ch),
        .cfg_fcw_i   (cfg_fcw),
        .cfg_phase_i (cfg_phase),
        .load_i      (load),
        .adv_i       (iss_valid_q),
        .adv_ch_i    (iss_ch_q),
        .phase_o     (phase)
    );

    // Outputs: zero whenever the owning stage or state is inactive.
    always_comb begin
        lut_addr   = iss_valid_q ? phase : '0;
        mix_i_in_1 = mix_valid_q ? mix_i_q : '0;
        mix_q_in_1 = mix_valid_q ? mix_q_q : '0;
        mix_i_in_2 = mix_valid_q ? lut_cos : '0;
        mix_q_in_2 = mix_valid_q ? lut_sin : '0;
        acc_valid  = (state_q == StDump);
        acc_ch     = acc_valid ? dump_ch_q : '0;
        acc_i      = acc_valid ? acc_i_q[dump_ch_q] : '0;
        acc_q      = acc_valid ? acc_q_q[dump_ch_q] : '0;
        busy       = (state_q != StIdle);
        done       = done_q;
    end

endmodule

// File: tb/tb_demod_mixer_scheduler.sv
// Randomised scoreboard bench for demod_mixer_scheduler with a LUT and mixer model.
module tb_demod_mixer_scheduler;

    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [9:0]  cfg_fcw, cfg_phase;
    logic        start;
    logic [15:0] win_len;
    logic        s_valid, s_ready;
    logic [15:0] s_i, s_q;
    logic [9:0]  lut_addr;
    logic [15:0] lut_cos, lut_sin;
    logic [15:0] mix_i_in_1, mix_q_in_1, mix_i_in_2, mix_q_in_2;
    logic [15:0] mix_i_out, mix_q_out;
    logic        acc_valid;
    logic [1:0]  acc_ch;
    logic [31:0] acc_i, acc_q;
    logic        busy, done;

    demod_mixer_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_fcw    (cfg_fcw),
        .cfg_phase  (cfg_phase),
        .start      (start),
        .win_len    (win_len),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_i        (s_i),
        .s_q        (s_q),
        .lut_addr   (lut_addr),
        .lut_cos    (lut_cos),
        .lut_sin    (lut_sin),
        .mix_i_in_1 (mix_i_in_1),
        .mix_q_in_1 (mix_q_in_1),
        .mix_i_in_2 (mix_i_in_2),
        .mix_q_in_2 (mix_q_in_2),
        .mix_i_out  (mix_i_out),
        .mix_q_out  (mix_q_out),
        .acc_valid  (acc_valid),
        .acc_ch     (acc_ch),
        .acc_i      (acc_i),
        .acc_q      (acc_q),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External LUT (1-cycle read latency) and Q1.15 multiplying mixer.
    logic signed [15:0] cos_tab [1024];
    logic signed [15:0] sin_tab [1024];

    function automatic logic signed [15:0] mixf(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
        logic signed [31:0] p;
        p = a * b;
        return p[30:15];
    endfunction

    always @(posedge clk) begin
        lut_cos <= cos_tab[lut_addr];
        lut_sin <= sin_tab[lut_addr];
    end
    assign mix_i_out = mixf(mix_i_in_1, mix_i_in_2);
    assign mix_q_out = mixf(mix_q_in_1, mix_q_in_2);

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    typedef struct {
        int          ch;
        logic [31:0] i;
        logic [31:0] q;
    } beat_t;
    beat_t exp_q[$];

    int          acc_t[$];
    logic [15:0] acc_si[$];
    logic [15:0] acc_sq[$];
    logic [9:0]  addr_log[int];
    bit          mon_en = 0;
    bit          expect_done = 0;
    int          done_cnt = 0;

    // Monitor: logs handshakes and LUT addresses, checks result beats and done.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (s_valid && s_ready) begin
                acc_t.push_back(cyc);
                acc_si.push_back(s_i);
                acc_sq.push_back(s_q);
            end
            addr_log[cyc] = lut_addr;
            if (expect_done) begin
                chk("done_pulse", {63'd0, done}, 64'd1);
                expect_done = 0;
            end else if (done) begin
                chk("unexpected_done", {63'd0, done}, 64'd0);
            end
            if (done) done_cnt++;
            if (acc_valid) begin
                if (exp_q.size() == 0) begin
                    chk("beat_unexpected", {63'd0, acc_valid}, 64'd0);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("beat_ch", {62'd0, acc_ch}, 64'(b.ch));
                    chk("beat_i", {32'd0, acc_i}, {32'd0, b.i});
                    chk("beat_q", {32'd0, acc_q}, {32'd0, b.q});
                    if (acc_ch == 2'd3) expect_done = 1;
                end
            end
            if (!busy) begin
                chk("idle_quiet", {lut_addr, mix_i_in_1, mix_q_in_1, mix_i_in_2, 3'd0,
                                   s_ready, acc_valid}, 64'd0);
            end
        end
    end

    // Reference model: programmed config and per-window shadow copy.
    int cfg_fcw_m [4];
    int cfg_ph_m  [4];
    int win_fcw   [4];
    int win_ph    [4];

    task automatic cfg_write(input int ch, input int fcw, input int ph);
        cfg_we = 1'b1;
        cfg_ch = 2'(ch);
        cfg_fcw = 10'(fcw);
        cfg_phase = 10'(ph);
        cfg_fcw_m[ch] = fcw % 1024;
        cfg_ph_m[ch] = ph % 1024;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    function automatic int exp_addr(input int c, input int k);
        return (win_ph[c] + k * win_fcw[c]) % 1024;
    endfunction

    task automatic push_expected(input int wl);
        for (int c = 0; c < 4; c++) begin
            beat_t b;
            int ei, eq, a;
            ei = 0;
            eq = 0;
            for (int k = 0; k < wl; k++) begin
                a = exp_addr(c, k);
                ei += int'(mixf(acc_si[k], cos_tab[a]));
                eq += int'(mixf(acc_sq[k], sin_tab[a]));
            end
            b.ch = c;
            b.i = ei;
            b.q = eq;
            exp_q.push_back(b);
        end
    endtask

    // One integration window: start, random sample stream, wait for done, then
    // check handshake count/spacing and the issued LUT address sequence.
    task automatic run_window(input int wl, input int pct, input bit mid_start,
                              input bit fixed_smp);
        int  base_done, n, s_cyc;
        bit  pushed;
        acc_t.delete();
        acc_si.delete();
        acc_sq.delete();
        for (int c = 0; c < 4; c++) begin
            win_fcw[c] = cfg_fcw_m[c];
            win_ph[c] = cfg_ph_m[c];
        end
        base_done = done_cnt;
        start = 1'b1;
        win_len = 16'(wl);
        s_cyc = cyc;
        pushed = 0;
        n = 0;
        while (done_cnt == base_done && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            start = 1'b0;
            if (mid_start && n == 3) begin
                start = 1'b1;
                win_len = 16'd2;
            end
            s_valid = ($urandom_range(99) < pct);
            s_i = fixed_smp ? 16'h0100 : 16'($urandom);
            s_q = fixed_smp ? 16'h0000 : 16'($urandom);
            if (!pushed && acc_t.size() == wl) begin
                push_expected(wl);
                pushed = 1;
            end
        end
        s_valid = 1'b0;
        start = 1'b0;
        if (n >= 3000) begin
            errors++;
            $display("FAIL window_timeout wl=%0d got no done want done", wl);
        end
        chk("accept_count", 64'(acc_t.size()), 64'(wl));
        chk("beats_drained", 64'(exp_q.size()), 64'd0);
        if (pct >= 100 && wl > 0) begin
            chk("first_accept", 64'(acc_t[0]), 64'(s_cyc + 1));
            for (int k = 1; k < acc_t.size(); k++)
                chk("accept_spacing", 64'(acc_t[k] - acc_t[k-1]), 64'd4);
        end
        for (int k = 0; k < acc_t.size() && k < wl; k++) begin
            for (int c = 0; c < 4; c++) begin
                int t;
                t = acc_t[k] + 1 + c;
                if (!addr_log.exists(t)) chk("lut_addr_missing", 64'd1, 64'd0);
                else chk("lut_addr", 64'(addr_log[t]), 64'(exp_addr(c, k)));
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) begin
            cos_tab[a] = 16'($urandom);
            sin_tab[a] = 16'($urandom);
        end
        for (int c = 0; c < 4; c++) begin
            cfg_fcw_m[c] = 0;
            cfg_ph_m[c] = 0;
        end
        rst = 1'b1;
        cfg_we = 1'b0;
        cfg_ch = '0;
        cfg_fcw = '0;
        cfg_phase = '0;
        start = 1'b0;
        win_len = '0;
        s_valid = 1'b0;
        s_i = '0;
        s_q = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_outputs", {s_ready, acc_valid, done, acc_ch, lut_addr, mix_i_in_1,
                            mix_q_in_1, mix_q_in_2}, 64'd0);
        chk("rst_acc", {acc_i, acc_q}, 64'd0);
        mon_en = 1;

        // Basic stepping: fcw 1..4 from phase 0, three samples back to back.
        for (int c = 0; c < 4; c++) cfg_write(c, c + 1, 0);
        run_window(3, 100, 0, 0);

        // Phase wraps past the top of the LUT.
        cfg_write(0, 1, 1023);
        cfg_write(1, 1000, 1023);
        run_window(3, 100, 0, 0);

        // Sustained rate with valid held high.
        run_window(8, 100, 0, 0);

        // Frozen NCOs with a constant sample.
        for (int c = 0; c < 4; c++) cfg_write(c, 0, 0);
        run_window(8, 100, 0, 1);

        // Start while busy is ignored; empty window dumps zeros.
        for (int c = 0; c < 4; c++) cfg_write(c, $urandom_range(1023), $urandom_range(1023));
        run_window(6, 100, 1, 0);
        run_window(0, 100, 0, 0);

        // Random configs, windows and valid duty.
        for (int w = 0; w < 6; w++) begin
            for (int c = 0; c < 4; c++)
                cfg_write(c, $urandom_range(1023), $urandom_range(1023));
            run_window($urandom_range(12, 1), $urandom_range(100, 30), 0, 0);
        end

        // Abort mid-window with reset.
        for (int c = 0; c < 4; c++) cfg_write(c, c + 5, 7);
        start = 1'b1;
        win_len = 16'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            s_valid = 1'b1;
            s_i = 16'($urandom);
            s_q = 16'($urandom);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_ready", {63'd0, s_ready}, 64'd0);
        chk("abort_acc_valid", {63'd0, acc_valid}, 64'd0);
        for (int c = 0; c < 4; c++) begin
            cfg_fcw_m[c] = 0;
            cfg_ph_m[c] = 0;
        end
        repeat (12) @(posedge clk);
        #1;

        // Config is cleared by reset, then a fresh basic window.
        run_window(2, 100, 0, 0);
        for (int c = 0; c < 4; c++) cfg_write(c, c + 1, 0);
        run_window(3, 100, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
